demux_frame_decoder: RTL
========================

// Module: demux_frame_decoder
// PURPOSE
//  Upstream feeder for the 1:16 demultiplexer. Receives a bit-serial command
//  frame (start bit, 4-bit channel address, data bit, optional parity) and
//  drives the demux sel/din. din is held for HOLD_CYCLES, then returned to 0,
//  so the selected demux output sees a clean pulse.
// PARAMETERS
//  HOLD_CYCLES  4   cycles din is driven after a good frame; legal range >= 1
//  TIMEOUT      16  max idle cycles between bits mid-frame before abort; 0 = no timeout
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  rx_bit       in   1  serial data bit, sampled only when rx_valid=1
//  rx_valid     in   1  bit strobe; one bit per cycle with rx_valid=1
//  sel          out  4  demux select (registered)
//  din          out  1  demux data input (registered)
//  frame_valid  out  1  1-cycle pulse: sel/din just updated from a good frame
//  frame_err    out  1  1-cycle pulse: frame aborted (timeout or parity)
//  busy         out  1  1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; sel=0, din=0, frame_valid=0, frame_err=0, busy=0; all counters 0.
//  Frame, MSB first: start(1), a3 a2 a1 a0, d, [p]. In IDLE, rx_valid with rx_bit=0 is ignored.
//  States and transitions:
//   IDLE   : rx_valid & rx_bit=1 -> ADDR, bit_cnt=0.
//   ADDR   : each rx_valid shifts rx_bit into addr_sr; after the 4th bit -> DATA.
//   DATA   : rx_valid captures d -> PARITY (macro on) or commit (macro off).
//   PARITY : rx_valid: p == ^{addr_sr,d} -> commit; else frame_err pulse -> IDLE.
//   commit : on the edge sampling the last bit: sel<=addr, din<=d, frame_valid<=1,
//            hold_cnt<=HOLD_CYCLES-1 -> HOLD.
//   HOLD   : rx_valid ignored; hold_cnt==0 -> din<=0, -> IDLE; else hold_cnt--.
//  Latency: sel/din/frame_valid update 1 clock after the final bit is presented.
//  din stays at d for exactly HOLD_CYCLES cycles. sel holds its value until the next good frame.
//  frame_valid and frame_err never assert in the same cycle; each is high for one cycle only.
//  Timeout (TIMEOUT>0, states ADDR/DATA/PARITY only):
//   - gap_cnt clears on every rx_valid and increments on each cycle without it.
//   - gap_cnt reaching TIMEOUT -> frame_err pulse -> IDLE; sel/din unchanged.
//  Back-to-back frames: a start bit is accepted on the first IDLE cycle after HOLD.
//   A start bit arriving during HOLD is dropped.
//  rst mid-frame or mid-HOLD: partial frame discarded; all outputs return to reset values next edge.
//  addr wraps naturally over 0..15; no illegal addresses.
// CONFIGURATION
//  DEMUX_FRAME_PARITY_EN defined:
//   - frame is 7 bits; PARITY state present.
//   - even parity: p must equal XOR of a3..a0 and d, else frame_err.
//  Undefined:
//   - frame is 6 bits; DATA commits directly.
//   - no parity logic and no parity error path; frame_err is raised only by timeout.
// TESTING
//  1 rst, then frame 1,0,0,0,1,1 (addr=1, d=1) on consecutive cycles -> sel=1, din=1 for 4 cycles,
//    frame_valid high 1 cycle starting 1 clk after the last bit, busy=0 after HOLD.
//  2 frame addr=4'b1111, d=0 -> sel=15, din=0, frame_valid pulse; then addr=2, d=1 back-to-back ->
//    second frame accepted, sel=2.
//  3 rx_valid=1, rx_bit=0 for 10 cycles in IDLE -> busy=0, sel/din unchanged, no pulses.
//  4 start + 2 addr bits, then rx_valid=0 for 16 cycles -> frame_err pulse on the 16th idle cycle,
//    busy=0, sel/din keep their prior values.
//  5 (DEMUX_FRAME_PARITY_EN) addr=3, d=1, p=0 -> frame_err, no frame_valid;
//    resend with p=1 -> sel=3, din=1.
//  6 rst=1 during ADDR -> all outputs 0 next edge; next clean frame addr=9, d=1 -> sel=9, din=1.

Source files
------------

// File: rtl/demux_frame_decoder.sv
// Serial command-frame decoder feeding a 1:16 demux: start, a3..a0, d[, p] -> sel/din pulse.
// Define DEMUX_FRAME_PARITY_EN to add the trailing even-parity bit and its error path.
module demux_frame_decoder #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_bit,
   input  logic       rx_valid,
   output logic [3:0] sel,
   output logic       din,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned GW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LIMIT = GW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
`ifdef DEMUX_FRAME_PARITY_EN
      PARITY,
`endif
      HOLD
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      bit_cnt_q, bit_cnt_d;
   logic [3:0]      addr_sr_q, addr_sr_d;
   logic            data_q, data_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [3:0]      sel_q, sel_d;
   logic            din_q, din_d;
   logic            frame_valid_q, frame_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            commit, abort, commit_data, timed_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         addr_sr_q     <= '0;
         data_q        <= 1'b0;
         gap_cnt_q     <= '0;
         hold_cnt_q    <= '0;
         sel_q         <= '0;
         din_q         <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         addr_sr_q     <= addr_sr_d;
         data_q        <= data_d;
         gap_cnt_q     <= gap_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         sel_q         <= sel_d;
         din_q         <= din_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      addr_sr_d   = addr_sr_q;
      data_d      = data_q;
      gap_cnt_d   = gap_cnt_q;
      commit      = 1'b0;
      abort       = 1'b0;
      commit_data = data_q;
      timed_out   = (TIMEOUT > 0) && !rx_valid && (gap_cnt_q == GAP_LIMIT);
      case (state_q)
         IDLE: begin
            if (rx_valid && rx_bit) begin
               state_d   = ADDR;
               bit_cnt_d = '0;
               gap_cnt_d = '0;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) state_d = IDLE;
         end
         default: begin
            // ADDR / DATA / PARITY share the inter-bit gap watchdog
            if (rx_valid) begin
               gap_cnt_d = '0;
               case (state_q)
                  ADDR: begin
                     addr_sr_d = {addr_sr_q[2:0], rx_bit};
                     bit_cnt_d = bit_cnt_q + 2'd1;
                     if (bit_cnt_q == 2'd3) state_d = DATA;
                  end
                  DATA: begin
                     data_d = rx_bit;
`ifdef DEMUX_FRAME_PARITY_EN
                     state_d = PARITY;
`else
                     commit      = 1'b1;
                     commit_data = rx_bit;
                     state_d     = HOLD;
`endif
                  end
`ifdef DEMUX_FRAME_PARITY_EN
                  PARITY: begin
                     if (rx_bit == ^{addr_sr_q, data_q}) begin
                        commit  = 1'b1;
                        state_d = HOLD;
                     end else begin
                        abort   = 1'b1;
                        state_d = IDLE;
                     end
                  end
`endif
                  default: state_d = IDLE;
               endcase
            end else if (timed_out) begin
               abort   = 1'b1;
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      sel_d         = sel_q;
      din_d         = din_q;
      hold_cnt_d    = hold_cnt_q;
      frame_valid_d = 1'b0;
      frame_err_d   = abort;
      if (commit) begin
         sel_d         = addr_sr_q;
         din_d         = commit_data;
         frame_valid_d = 1'b1;
         hold_cnt_d    = HOLD_LOAD;
      end else if (state_q == HOLD) begin
         if (hold_cnt_q == '0) din_d = 1'b0;
         else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
   end

   assign sel         = sel_q;
   assign din         = din_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign busy        = (state_q != IDLE);

endmodule
